// File: rtl/input_vc_buffer_if.sv
// Flit/credit bundle between one router input port and its VC buffer.
interface input_vc_buffer_if #(
  parameter int NUM_VCS = 4
);
  logic [21:0]        in_flit;
  logic [4:0]         rd_vc;
  logic               deq;
  logic [21:0]        head_flit;
  logic [NUM_VCS-1:0] vc_nonempty;
  logic [21:0]        cr_out;
  logic               err;

  // Router side: supplies flits, selects and consumes heads, receives credits.
  modport master (
    output in_flit, rd_vc, deq,
    input  head_flit, vc_nonempty, cr_out, err
  );

  // Buffer side.
  modport slave (
    input  in_flit, rd_vc, deq,
    output head_flit, vc_nonempty, cr_out, err
  );
endinterface

// File: rtl/input_vc_buffer.sv
// Per-input-port virtual-channel flit buffer: NUM_VCS circular FIFOs of
// DEPTH flits, head-of-VC read port, one credit returned per consumed flit.
module input_vc_buffer #(
  parameter int NUM_VCS = 4,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input_vc_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [21:0]        mem    [NUM_VCS][DEPTH];
  logic [PW-1:0]      rd_ptr [NUM_VCS];
  logic [PW-1:0]      wr_ptr [NUM_VCS];
  logic [CW-1:0]      count  [NUM_VCS];
  logic [NUM_VCS-1:0] enq_ok;
  logic [NUM_VCS-1:0] deq_ok;
  logic [NUM_VCS-1:0] nonempty;
  logic               err_set;
  logic               err_q;
  logic [21:0]        cr_q;
  logic [21:0]        head;
  logic               in_valid;
  logic [4:0]         in_vc;

  assign in_valid = bus.in_flit[21];
  assign in_vc    = bus.in_flit[20:16];

  // Decode enqueue/dequeue per VC; full check credits a same-VC dequeue.
  always_comb begin
    enq_ok  = '0;
    deq_ok  = '0;
    err_set = 1'b0;
    if (in_valid && (32'(in_vc) >= NUM_VCS))
      err_set = 1'b1;
    if (bus.deq && (32'(bus.rd_vc) >= NUM_VCS))
      err_set = 1'b1;
    for (int unsigned i = 0; i < NUM_VCS; i++) begin
      if (bus.deq && (bus.rd_vc == 5'(i))) begin
        if (count[i] != '0) deq_ok[i] = 1'b1;
        else                err_set   = 1'b1;
      end
      if (in_valid && (in_vc == 5'(i))) begin
        if ((count[i] != CW'(DEPTH)) || deq_ok[i]) enq_ok[i] = 1'b1;
        else                                       err_set   = 1'b1;
      end
    end
  end

  // Head-of-VC mux and occupancy flags, purely from registered state.
  always_comb begin
    head     = '0;
    nonempty = '0;
    for (int unsigned i = 0; i < NUM_VCS; i++) begin
      nonempty[i] = (count[i] != '0);
      if (bus.rd_vc == 5'(i))
        head = {nonempty[i], mem[i][rd_ptr[i]][20:0]};
    end
  end

  // Pointers, counts, credit and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_VCS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      cr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_VCS; i++) begin
        if (enq_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (deq_ok[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CW'(enq_ok[i]) - CW'(deq_ok[i]);
      end
      cr_q  <= (|deq_ok) ? {1'b1, bus.rd_vc, 16'h0000} : '0;
      err_q <= err_q | err_set;
    end
  end

  // Flit storage; contents are don't-care until counted, so no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_VCS; i++)
      if (enq_ok[i]) mem[i][wr_ptr[i]] <= bus.in_flit;
  end

  assign bus.head_flit   = head;
  assign bus.vc_nonempty = nonempty;
  assign bus.cr_out      = cr_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed bench for input_vc_buffer with a queue-based scoreboard for
// consumed head flits and returned credits.
module tb_input_vc_buffer;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  logic [21:0] head_q [$];
  logic [21:0] cr_q   [$];

  input_vc_buffer_if #(.NUM_VCS(4)) bus ();

  input_vc_buffer #(.NUM_VCS(4), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (time %0t, required < 200000)", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  function automatic logic [21:0] flit(input int vc, input int dest, input bit h, input bit t);
    return {1'b1, 5'(vc), h, t, 14'(dest)};
  endfunction

  function automatic logic [21:0] credit(input int vc);
    return {1'b1, 5'(vc), 16'h0000};
  endfunction

  // Monitor: consumed heads and returned credits checked against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.deq && bus.head_flit[21]) begin
        if (head_q.size() == 0) chk("unexpected_head", 32'(bus.head_flit), 32'h0);
        else chk("head_flit", 32'(bus.head_flit), 32'(head_q.pop_front()));
      end
      if (bus.cr_out[21]) begin
        if (cr_q.size() == 0) chk("unexpected_credit", 32'(bus.cr_out), 32'h0);
        else chk("cr_out", 32'(bus.cr_out), 32'(cr_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [21:0] f);
    bus.in_flit = f;
    step();
    bus.in_flit = '0;
  endtask

  task automatic deq_one(input int vc, input logic [21:0] exp_head, input bit exp_cr);
    bus.rd_vc = 5'(vc);
    bus.deq   = 1'b1;
    head_q.push_back(exp_head);
    if (exp_cr) cr_q.push_back(credit(vc));
    step();
    bus.deq = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    bus.in_flit = '0;
    bus.rd_vc   = '0;
    bus.deq     = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_cr_out", 32'(bus.cr_out), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_vc_nonempty", 32'(bus.vc_nonempty), 32'h0);
    chk("rst_head_valid", 32'(bus.head_flit[21]), 32'h0);
    rst_n = 1'b1;
    step();

    // Fill VC 2; first flit visible right after its edge
    bus.rd_vc = 5'd2;
    enq(flit(2, 14'h0011, 1'b1, 1'b0));
    chk("enq_latency_nonempty", 32'(bus.vc_nonempty), 32'h4);
    chk("enq_latency_head", 32'(bus.head_flit), 32'(flit(2, 14'h0011, 1'b1, 1'b0)));
    enq(flit(2, 14'h0012, 1'b0, 1'b0));
    enq(flit(2, 14'h0013, 1'b0, 1'b0));
    enq(flit(2, 14'h0014, 1'b0, 1'b1));
    chk("fill_nonempty", 32'(bus.vc_nonempty), 32'h4);
    chk("fill_head", 32'(bus.head_flit), 32'(flit(2, 14'h0011, 1'b1, 1'b0)));
    chk("fill_err", 32'(bus.err), 32'h0);

    // Drain VC 2 back-to-back
    deq_one(2, flit(2, 14'h0011, 1'b1, 1'b0), 1'b1);
    deq_one(2, flit(2, 14'h0012, 1'b0, 1'b0), 1'b1);
    deq_one(2, flit(2, 14'h0013, 1'b0, 1'b0), 1'b1);
    deq_one(2, flit(2, 14'h0014, 1'b0, 1'b1), 1'b1);
    chk("drain_last_credit", 32'(bus.cr_out), 32'(credit(2)));
    step();
    chk("drain_cr_idle", 32'(bus.cr_out), 32'h0);
    chk("drain_nonempty", 32'(bus.vc_nonempty), 32'h0);
    chk("drain_head_valid", 32'(bus.head_flit[21]), 32'h0);

    // VC 1 full, enqueue and dequeue same VC in one cycle
    for (int i = 1; i <= 4; i++) enq(flit(1, 14'h0100 + i, 1'b0, 1'b0));
    bus.in_flit = flit(1, 14'h0AAA, 1'b0, 1'b1);
    deq_one(1, flit(1, 14'h0101, 1'b0, 1'b0), 1'b1);
    bus.in_flit = '0;
    chk("fullswap_err", 32'(bus.err), 32'h0);
    chk("fullswap_nonempty", 32'(bus.vc_nonempty), 32'h2);
    deq_one(1, flit(1, 14'h0102, 1'b0, 1'b0), 1'b1);
    deq_one(1, flit(1, 14'h0103, 1'b0, 1'b0), 1'b1);
    deq_one(1, flit(1, 14'h0104, 1'b0, 1'b0), 1'b1);
    deq_one(1, flit(1, 14'h0AAA, 1'b0, 1'b1), 1'b1);
    step();
    chk("fullswap_empty_after", 32'(bus.vc_nonempty), 32'h0);

    // Overflow VC 3
    for (int i = 1; i <= 4; i++) enq(flit(3, 14'h0300 + i, 1'b0, 1'b0));
    chk("ovf_err_before", 32'(bus.err), 32'h0);
    enq(flit(3, 14'h03FF, 1'b0, 1'b1));
    chk("ovf_err", 32'(bus.err), 32'h1);
    step();
    step();
    chk("ovf_err_sticky", 32'(bus.err), 32'h1);
    for (int i = 1; i <= 4; i++) deq_one(3, flit(3, 14'h0300 + i, 1'b0, 1'b0), 1'b1);
    step();
    chk("ovf_dropped", 32'(bus.vc_nonempty), 32'h0);
    chk("ovf_err_still", 32'(bus.err), 32'h1);

    // Dequeue of empty VC 0
    do_reset();
    chk("reset_clears_err", 32'(bus.err), 32'h0);
    bus.rd_vc = 5'd0;
    bus.deq   = 1'b1;
    step();
    bus.deq   = 1'b0;
    chk("empty_deq_err", 32'(bus.err), 32'h1);
    chk("empty_deq_no_credit", 32'(bus.cr_out), 32'h0);
    chk("empty_deq_nonempty", 32'(bus.vc_nonempty), 32'h0);

    // Enqueue to vc = NUM_VCS
    do_reset();
    enq(flit(4, 14'h0444, 1'b1, 1'b1));
    chk("badvc_err", 32'(bus.err), 32'h1);
    chk("badvc_nonempty", 32'(bus.vc_nonempty), 32'h0);

    // Reset mid-stream with a credit pending
    do_reset();
    bus.rd_vc = 5'd0;
    enq(flit(0, 14'h00A1, 1'b1, 1'b0));
    enq(flit(0, 14'h00A2, 1'b0, 1'b1));
    deq_one(0, flit(0, 14'h00A1, 1'b1, 1'b0), 1'b0);
    chk("midrst_credit_pending", 32'(bus.cr_out), 32'(credit(0)));
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_cr_async", 32'(bus.cr_out), 32'h0);
    chk("midrst_nonempty", 32'(bus.vc_nonempty), 32'h0);
    chk("midrst_head_valid", 32'(bus.head_flit[21]), 32'h0);
    step();
    rst_n = 1'b1;
    enq(flit(0, 14'h00B1, 1'b1, 1'b1));
    chk("midrst_first_enq_head", 32'(bus.head_flit), 32'(flit(0, 14'h00B1, 1'b1, 1'b1)));
    chk("midrst_first_enq_nonempty", 32'(bus.vc_nonempty), 32'h1);
    deq_one(0, flit(0, 14'h00B1, 1'b1, 1'b1), 1'b1);
    step();
    step();
    chk("head_queue_drained", 32'(head_q.size()), 32'h0);
    chk("credit_queue_drained", 32'(cr_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/input_vc_buffer.md
# input_vc_buffer

Per-input-port virtual-channel flit buffer that sits directly upstream of `router`. It captures flits arriving on one 22-bit staging lane into per-VC FIFOs and presents the head flit of a selected VC to the router. On every flit the router consumes, it returns a credit on the 22-bit credit lane toward the upstream sender. One instance exists per router input port; `router` concatenates the lanes into `in_staging_pl` / `cr_staging_pl`.

## Interface
- `NUM_VCS`, default 4: virtual channels per port, 1..32.
- `DEPTH`, default 4: flit slots per VC, power of two, 2..16.
- `clk`  in  1: single clock, all state updates on posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_flit`  in  22: arriving flit.
  - [21] valid; [20:16] vc; [15] head; [14] tail; [13:0] dest.
- `rd_vc`  in  5: VC whose head flit is presented on `head_flit`.
- `deq`  in  1: router consumes the head flit of `rd_vc` this cycle.
- `head_flit`  out  22: head entry of `rd_vc`; bit [21] forced 0 when that VC is empty.
- `vc_nonempty`  out  NUM_VCS: bit i = VC i holds at least one flit.
- `cr_out`  out  22: credit.
  - [21] valid; [20:16] vc; [15:0] zero.
- `err`  out  1: sticky protocol-error flag.

## Operation
- **Storage:** NUM_VCS circular FIFOs of DEPTH x 22 bits.
  - Per-VC rd_ptr and wr_ptr, log2(DEPTH) bits, wrapping modulo DEPTH.
  - Per-VC count, log2(DEPTH)+1 bits, range 0..DEPTH.
- **Enqueue:** when `in_flit[21]`=1 and vc < NUM_VCS, the flit is written at wr_ptr[vc], wr_ptr increments, and count increments.
- **Dequeue:** when `deq`=1, `rd_vc` < NUM_VCS and count[rd_vc]>0:
  - rd_ptr[rd_vc] increments and count decrements.
  - `cr_out` on the next cycle is {1, rd_vc, 16'b0}.
- **Simultaneous enqueue and dequeue:**
  - Different VCs: both take effect independently.
  - Same VC: count is unchanged.
  - Same VC while full (count=DEPTH): the enqueue is accepted, because the freed slot is reused. The full check uses count minus the same-cycle dequeue.
- **Error cases (flit/credit dropped or no-op, `err` set, sticky until reset):**
  - Enqueue to a full VC with no same-cycle dequeue of that VC: flit dropped.
  - Enqueue with vc >= NUM_VCS: flit dropped.
  - `deq`=1 with an empty `rd_vc`, or with rd_vc >= NUM_VCS: no pointer change, no credit.
- **Head read path:** `head_flit` and `vc_nonempty` are combinational from registered state. There is no enqueue-to-head bypass.
- **Flit fields:** head/tail/dest are stored and forwarded unmodified. The buffer does no packet-level checking.

## Timing
- **Reset (asynchronous assert, synchronous release on next posedge):**
  - All pointers and counts are 0.
  - `cr_out`=0, `err`=0, `vc_nonempty`=0.
  - `head_flit[21]`=0.
- **Enqueue latency:** a flit sampled at edge N is visible on `head_flit` (with `rd_vc` selecting it) and on `vc_nonempty` after edge N, i.e. in cycle N+1.
- **Dequeue to credit:**
  - A `deq` sampled at edge N produces `cr_out[21]`=1 during cycle N+1 only.
  - One credit per consumed flit; back-to-back dequeues give back-to-back credits.
  - Credit delay beyond this one cycle is applied by the receiver's credit queue, not here.
- **Dequeue effect:** after the edge, `head_flit` shows the next entry, or valid=0 if the VC is now empty.
- **Throughput:** one enqueue and one dequeue per cycle, sustained.
- **Reset mid-operation:** all buffered flits are discarded, and any pending credit is dropped (`cr_out` goes 0 immediately).
- **Pointer wrap:** after DEPTH enqueues, wr_ptr returns to 0 with no bubble.

## Test plan
- **Reset and fill:** reset, then enqueue 4 flits on VC 2 (dest 0x0011..0x0014) with DEPTH=4.
  - `vc_nonempty`=4'b0100.
  - `rd_vc`=2 shows dest 0x0011.
  - `err`=0.
- **Drain and credits:** dequeue VC 2 four consecutive cycles.
  - `head_flit` dest steps 0x0011→0x0014.
  - `cr_out` = {1,5'd2,0} on four consecutive cycles, then 0.
  - `vc_nonempty`=0.
- **Full with same-cycle dequeue:** VC 1 full; enqueue VC 1 (dest 0x0AAA) while dequeuing VC 1.
  - Enqueue is accepted; count stays 4; `err`=0.
  - The fifth flit emerges last, after the three older flits still buffered.
- **Overflow:** VC 3 full; enqueue VC 3 with no dequeue.
  - Flit dropped; `err`=1 and stays 1.
  - Contents of VC 3 are unchanged.
- **Empty dequeue and bad VC:** `deq`=1 on empty VC 0, and separately enqueue with vc=NUM_VCS.
  - No credit; no state change; `err`=1.
- **Reset mid-stream:** assert `rst_n`=0 in the cycle after a dequeue.
  - `cr_out` drops to 0 asynchronously.
  - All counts are 0.
  - After release, the first enqueue lands in slot 0.
